// File: rtl/banco_registros_wb_if.sv
// banco_registros_wb_if
//   Bus between the decode/write-back logic and the register bank.
//   master: drives the write request and both read addresses, receives
//           the read data and the pending-write flag.
//   slave : the register bank itself.
//   Signals:
//     Esc_Reg         write request this cycle
//     Dir_Escritura   write address (from the write-register selector)
//     Dato_Escritura  write data
//     Dir_Lectura1/2  read addresses
//     Dato_Lectura1/2 read data (combinational in the bank)
//     Escritura_Pend  staging register holds an uncommitted write
interface banco_registros_wb_if #(
  parameter int ANCHO_DATO = 32,
  parameter int ANCHO_DIR  = 5
);
  logic                  Esc_Reg;
  logic [ANCHO_DIR-1:0]  Dir_Escritura;
  logic [ANCHO_DATO-1:0] Dato_Escritura;
  logic [ANCHO_DIR-1:0]  Dir_Lectura1;
  logic [ANCHO_DIR-1:0]  Dir_Lectura2;
  logic [ANCHO_DATO-1:0] Dato_Lectura1;
  logic [ANCHO_DATO-1:0] Dato_Lectura2;
  logic                  Escritura_Pend;

  modport master (
    output Esc_Reg, Dir_Escritura, Dato_Escritura, Dir_Lectura1, Dir_Lectura2,
    input  Dato_Lectura1, Dato_Lectura2, Escritura_Pend
  );

  modport slave (
    input  Esc_Reg, Dir_Escritura, Dato_Escritura, Dir_Lectura1, Dir_Lectura2,
    output Dato_Lectura1, Dato_Lectura2, Escritura_Pend
  );
endinterface

// File: rtl/banco_registros_wb.sv
// banco_registros_wb
//   32-entry general-purpose register bank on the write-back side of the
//   datapath. Writes are captured into a one-entry staging register and
//   committed to the array on the following edge; the staging register is
//   bypassed to both asynchronous read ports, so decode sees a written
//   value one cycle after the write is presented.
//   Ports:
//     Clk    system clock, rising edge
//     Reset  asynchronous, active-high reset
//     bus    banco_registros_wb_if.slave (write request, read ports, pending flag)
module banco_registros_wb #(
  parameter int ANCHO_DATO = 32,
  parameter int ANCHO_DIR  = 5,
  parameter int NUM_REGS   = 2 ** ANCHO_DIR
) (
  input  logic                  Clk,
  input  logic                  Reset,
  banco_registros_wb_if.slave   bus
);

  logic [ANCHO_DATO-1:0] r_regs [NUM_REGS];
  logic                  r_staged_valid;
  logic [ANCHO_DIR-1:0]  r_staged_dir;
  logic [ANCHO_DATO-1:0] r_staged_dato;

  logic                  w_stage_en;
  logic [ANCHO_DATO-1:0] w_dato1;
  logic [ANCHO_DATO-1:0] w_dato2;

  // Register 0 is hardwired to zero, so a write to it is dropped before it
  // ever reaches the staging register.
  assign w_stage_en = bus.Esc_Reg && (bus.Dir_Escritura != '0);

  // Commit and capture share one edge: the commit uses the staging contents
  // from before this edge, then the staging register takes the new request.
  // Reset clears the staging register too, so a write caught mid-flight is
  // lost rather than committed.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_staged_valid <= 1'b0;
      r_staged_dir   <= '0;
      r_staged_dato  <= '0;
    end else begin
      if (r_staged_valid) begin
        r_regs[r_staged_dir] <= r_staged_dato;
      end
      r_staged_valid <= w_stage_en;
      r_staged_dir   <= bus.Dir_Escritura;
      r_staged_dato  <= bus.Dato_Escritura;
    end
  end

  // Read priority: zero register, then the staged write, then the array.
  // The write presented on the inputs this cycle is deliberately not
  // forwarded; only the staged value is.
  assign w_dato1 = (bus.Dir_Lectura1 == '0) ? '0 :
                   (r_staged_valid && (bus.Dir_Lectura1 == r_staged_dir)) ? r_staged_dato :
                   r_regs[bus.Dir_Lectura1];

  assign w_dato2 = (bus.Dir_Lectura2 == '0) ? '0 :
                   (r_staged_valid && (bus.Dir_Lectura2 == r_staged_dir)) ? r_staged_dato :
                   r_regs[bus.Dir_Lectura2];

  assign bus.Dato_Lectura1  = w_dato1;
  assign bus.Dato_Lectura2  = w_dato2;
  assign bus.Escritura_Pend = r_staged_valid;

endmodule

// File: tb/tb_banco_registros_wb.sv
module tb_banco_registros_wb;

  logic Clk;
  logic Reset;

  banco_registros_wb_if #(.ANCHO_DATO(32), .ANCHO_DIR(5)) bus ();

  banco_registros_wb #(.ANCHO_DATO(32), .ANCHO_DIR(5), .NUM_REGS(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] q_exp [$];
  string       q_tag [$];

  task automatic expect_val(input string t, input logic [31:0] e);
    q_exp.push_back(e);
    q_tag.push_back(t);
  endtask

  task automatic check_next(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    checks++;
    if (q_exp.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
      return;
    end
    e = q_exp.pop_front();
    t = q_tag.pop_front();
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] e);
    expect_val(t, e);
    check_next(obs);
  endtask

  initial begin
    Reset              = 1'b1;
    bus.Esc_Reg        = 1'b0;
    bus.Dir_Escritura  = '0;
    bus.Dato_Escritura = '0;
    bus.Dir_Lectura1   = '0;
    bus.Dir_Lectura2   = '0;

    // 1. reset released mid-cycle, whole bank reads zero
    #12 Reset = 1'b0;
    #1;
    chk("t1_pend", {31'b0, bus.Escritura_Pend}, 32'h0);
    for (int a = 0; a < 32; a++) begin
      bus.Dir_Lectura1 = 5'(a);
      bus.Dir_Lectura2 = 5'(31 - a);
      #1;
      chk($sformatf("t1_rd1_a%0d", a), bus.Dato_Lectura1, 32'h0);
      chk($sformatf("t1_rd2_a%0d", 31 - a), bus.Dato_Lectura2, 32'h0);
    end

    // 2. single write to r5, bypass then resident
    step();
    bus.Esc_Reg        = 1'b1;
    bus.Dir_Escritura  = 5'd5;
    bus.Dato_Escritura = 32'h0000_00A5;
    bus.Dir_Lectura1   = 5'd5;
    #1;
    chk("t2_rd1_pre_edge", bus.Dato_Lectura1, 32'h0);
    chk("t2_pend_pre_edge", {31'b0, bus.Escritura_Pend}, 32'h0);
    step();
    bus.Esc_Reg = 1'b0;
    chk("t2_rd1_edge1", bus.Dato_Lectura1, 32'h0000_00A5);
    chk("t2_pend_edge1", {31'b0, bus.Escritura_Pend}, 32'h1);
    step();
    chk("t2_rd1_edge2", bus.Dato_Lectura1, 32'h0000_00A5);
    chk("t2_pend_edge2", {31'b0, bus.Escritura_Pend}, 32'h0);

    // 3. write to r0 is ignored
    bus.Esc_Reg        = 1'b1;
    bus.Dir_Escritura  = 5'd0;
    bus.Dato_Escritura = 32'hFFFF_FFFF;
    bus.Dir_Lectura1   = 5'd0;
    bus.Dir_Lectura2   = 5'd0;
    step();
    bus.Esc_Reg = 1'b0;
    chk("t3_pend_edge1", {31'b0, bus.Escritura_Pend}, 32'h0);
    chk("t3_rd1_edge1", bus.Dato_Lectura1, 32'h0);
    chk("t3_rd2_edge1", bus.Dato_Lectura2, 32'h0);
    step();
    chk("t3_rd1_edge2", bus.Dato_Lectura1, 32'h0);
    chk("t3_rd2_edge2", bus.Dato_Lectura2, 32'h0);
    bus.Dir_Lectura1 = 5'd5;
    #1;
    chk("t3_r5_kept", bus.Dato_Lectura1, 32'h0000_00A5);

    // 4. back-to-back writes to r31
    bus.Esc_Reg        = 1'b1;
    bus.Dir_Escritura  = 5'd31;
    bus.Dato_Escritura = 32'h0000_1234;
    bus.Dir_Lectura2   = 5'd31;
    step();
    bus.Dato_Escritura = 32'h0000_5678;
    chk("t4_rd2_edge1", bus.Dato_Lectura2, 32'h0000_1234);
    chk("t4_pend_edge1", {31'b0, bus.Escritura_Pend}, 32'h1);
    step();
    bus.Esc_Reg = 1'b0;
    chk("t4_rd2_edge2", bus.Dato_Lectura2, 32'h0000_5678);
    chk("t4_pend_edge2", {31'b0, bus.Escritura_Pend}, 32'h1);
    step();
    chk("t4_rd2_edge3", bus.Dato_Lectura2, 32'h0000_5678);
    chk("t4_pend_edge3", {31'b0, bus.Escritura_Pend}, 32'h0);

    // 5. reset discards a staged write
    bus.Esc_Reg        = 1'b1;
    bus.Dir_Escritura  = 5'd7;
    bus.Dato_Escritura = 32'h0000_DEAD;
    bus.Dir_Lectura1   = 5'd7;
    step();
    bus.Esc_Reg = 1'b0;
    chk("t5_rd1_staged", bus.Dato_Lectura1, 32'h0000_DEAD);
    chk("t5_pend_staged", {31'b0, bus.Escritura_Pend}, 32'h1);
    #2 Reset = 1'b1;
    #1;
    chk("t5_pend_in_reset", {31'b0, bus.Escritura_Pend}, 32'h0);
    chk("t5_rd1_in_reset", bus.Dato_Lectura1, 32'h0);
    @(posedge Clk);
    #3 Reset = 1'b0;
    #1;
    chk("t5_rd1_release", bus.Dato_Lectura1, 32'h0);
    step();
    chk("t5_rd1_after_edge", bus.Dato_Lectura1, 32'h0);
    chk("t5_pend_after_edge", {31'b0, bus.Escritura_Pend}, 32'h0);
    bus.Dir_Lectura2 = 5'd31;
    #1;
    chk("t5_r31_cleared", bus.Dato_Lectura2, 32'h0);

    // 6. dual-port reads; current-cycle input write is not forwarded
    bus.Esc_Reg        = 1'b1;
    bus.Dir_Escritura  = 5'd9;
    bus.Dato_Escritura = 32'h0000_0F0F;
    step();
    bus.Dir_Escritura  = 5'd4;
    bus.Dato_Escritura = 32'h0000_1111;
    bus.Dir_Lectura2   = 5'd4;
    #1;
    chk("t6_no_input_bypass", bus.Dato_Lectura2, 32'h0);
    step();
    bus.Esc_Reg = 1'b0;
    step();
    bus.Dir_Lectura1 = 5'd9;
    bus.Dir_Lectura2 = 5'd9;
    #1;
    chk("t6_rd1_r9", bus.Dato_Lectura1, 32'h0000_0F0F);
    chk("t6_rd2_r9", bus.Dato_Lectura2, 32'h0000_0F0F);
    bus.Dir_Lectura2 = 5'd4;
    #1;
    chk("t6_rd2_r4", bus.Dato_Lectura2, 32'h0000_1111);
    chk("t6_rd1_r9_again", bus.Dato_Lectura1, 32'h0000_0F0F);

    checks++;
    assert (q_exp.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", q_exp.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
